uart_imem_loader: RTL

Boot loader that receives a framed program image as a byte stream from the UART receiver and writes it, word by word, into instruction memory. It is the write side of the instruction memory that `if_stage` reads. It holds the CPU pipeline in reset until an image with a valid checksum has been written, then returns ACK (0x06) or NAK (0x15) to the host through the UART transmitter.

---
 rtl/rv_pkg.sv | 17 +
 rtl/loader_word_asm.sv | 50 +++++
 rtl/uart_imem_loader.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared types and constants for the instruction memory boot loader
package rv_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_LO = 3'd1,
    LEN_HI = 3'd2,
    DATA   = 3'd3,
    CSUM   = 3'd4,
    RESP   = 3'd5
  } loader_state_t;

  localparam logic [7:0] LOADER_MAGIC = 8'hA5;
  localparam logic [7:0] LOADER_ACK   = 8'h06;
  localparam logic [7:0] LOADER_NAK   = 8'h15;

endpackage

// File: rtl/loader_word_asm.sv
// rtl/loader_word_asm.sv - packs little-endian bytes into 32-bit words and drives the imem write port
module loader_word_asm #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              word_done,
  output logic              we,
  output logic [ADDR_W-1:0] addr,
  output logic [31:0]       wdata
);

  logic [1:0]  lane;
  logic [23:0] sh;

  assign word_done = byte_valid && (lane == 2'd3);

  // addr names the word being written while we is high and advances right after
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane  <= 2'd0;
      sh    <= 24'd0;
      we    <= 1'b0;
      addr  <= '0;
      wdata <= 32'd0;
    end else begin
      we <= word_done;
      if (clear) begin
        lane <= 2'd0;
        addr <= '0;
      end else begin
        if (we) begin
          addr <= addr + ADDR_W'(1);
        end
        if (byte_valid) begin
          lane <= lane + 2'd1;
          if (lane == 2'd3) begin
            wdata <= {byte_data, sh};
          end else begin
            sh <= {byte_data, sh[23:8]};
          end
        end
      end
    end
  end

endmodule

// File: rtl/uart_imem_loader.sv
// rtl/uart_imem_loader.sv - UART framed boot loader: frame FSM, checksum, timeout and ACK/NAK reply
module uart_imem_loader
  import rv_pkg::*;
#(
  parameter int IMEM_WORDS     = 1024,
  parameter int ADDR_W         = $clog2(IMEM_WORDS),
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_rx_valid,
  input  logic [7:0]        i_rx_data,
  output logic              o_tx_valid,
  output logic [7:0]        o_tx_data,
  input  logic              i_tx_ready,
  output logic              o_imem_we,
  output logic [ADDR_W-1:0] o_imem_addr,
  output logic [31:0]       o_imem_wdata,
  output logic              o_cpu_hold,
  output logic              o_load_ok
);

  localparam int              TO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [16:0]     MAX_N   = 17'(IMEM_WORDS);

  loader_state_t   state;
  logic [7:0]      len_lo;
  logic [7:0]      csum;
  logic [15:0]     words_left;
  logic [TO_W-1:0] to_cnt;
  logic [15:0]     len_full;
  logic            in_frame;
  logic            expired;
  logic            frame_start;
  logic            asm_valid;
  logic            word_done;

  assign in_frame    = (state == LEN_LO) || (state == LEN_HI) || (state == DATA) || (state == CSUM);
  // a byte arriving in the expiry cycle wins and reloads the counter
  assign expired     = in_frame && !i_rx_valid && (to_cnt == TO_LAST);
  assign frame_start = (state == IDLE) && i_rx_valid && (i_rx_data == LOADER_MAGIC);
  assign asm_valid   = (state == DATA) && i_rx_valid;
  assign len_full    = {i_rx_data, len_lo};

  loader_word_asm #(.ADDR_W(ADDR_W)) u_word_asm (
    .clk        (i_clk),
    .rst        (i_rst),
    .clear      (frame_start),
    .byte_valid (asm_valid),
    .byte_data  (i_rx_data),
    .word_done  (word_done),
    .we         (o_imem_we),
    .addr       (o_imem_addr),
    .wdata      (o_imem_wdata)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= IDLE;
      len_lo     <= 8'd0;
      csum       <= 8'd0;
      words_left <= 16'd0;
      to_cnt     <= '0;
      o_tx_valid <= 1'b0;
      o_tx_data  <= 8'd0;
      o_cpu_hold <= 1'b1;
      o_load_ok  <= 1'b0;
    end else begin
      if (in_frame && !i_rx_valid && !expired) begin
        to_cnt <= to_cnt + TO_W'(1);
      end else begin
        to_cnt <= '0;
      end

      if (expired) begin
        state      <= RESP;
        o_tx_valid <= 1'b1;
        o_tx_data  <= LOADER_NAK;
      end else begin
        case (state)
          IDLE: begin
            if (frame_start) begin
              state      <= LEN_LO;
              o_cpu_hold <= 1'b1;
              o_load_ok  <= 1'b0;
              csum       <= 8'd0;
            end
          end
          LEN_LO: begin
            if (i_rx_valid) begin
              len_lo <= i_rx_data;
              csum   <= csum ^ i_rx_data;
              state  <= LEN_HI;
            end
          end
          LEN_HI: begin
            if (i_rx_valid) begin
              csum       <= csum ^ i_rx_data;
              words_left <= len_full;
              if ((len_full == 16'd0) || ({1'b0, len_full} > MAX_N)) begin
                state      <= RESP;
                o_tx_valid <= 1'b1;
                o_tx_data  <= LOADER_NAK;
              end else begin
                state <= DATA;
              end
            end
          end
          DATA: begin
            if (i_rx_valid) begin
              csum <= csum ^ i_rx_data;
              if (word_done) begin
                words_left <= words_left - 16'd1;
                if (words_left == 16'd1) begin
                  state <= CSUM;
                end
              end
            end
          end
          CSUM: begin
            if (i_rx_valid) begin
              state      <= RESP;
              o_tx_valid <= 1'b1;
              o_tx_data  <= (i_rx_data == csum) ? LOADER_ACK : LOADER_NAK;
            end
          end
          RESP: begin
            if (o_tx_valid && i_tx_ready) begin
              o_tx_valid <= 1'b0;
              state      <= IDLE;
              if (o_tx_data == LOADER_ACK) begin
                o_cpu_hold <= 1'b0;
                o_load_ok  <= 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
